// File: rtl/object_sprite_drawer.sv
// object_sprite_drawer: picks pseudo-random object positions and rasterises
// an 8x8 gold or stone sprite into the VGA adapter, one pixel per clock.
//
// Handshake: enable_draw_gold / enable_draw_stone are level requests from the
// game view FSM. A request seen in IDLE starts one sprite. The block answers
// with a one-cycle draw_*_done pulse when the last pixel has been plotted. It
// then waits in WAIT until both requests are low, so a request that is still
// high cannot start a second sprite.
module object_sprite_drawer #(
  parameter int          SPRITE_W     = 8,
  parameter int          SPRITE_H     = 8,
  parameter int          X_MIN        = 16,
  parameter int          Y_MIN        = 40,
  parameter logic [2:0]  GOLD_COLOUR  = 3'b110,
  parameter logic [2:0]  STONE_COLOUR = 3'b111,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       resetn_gold_stone,
  input  logic       enable_random,
  input  logic       enable_draw_gold,
  input  logic       enable_draw_stone,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_gold_done,
  output logic       draw_stone_done,
  output logic [2:0] gold_count,
  output logic [2:0] stone_count,
  output logic [7:0] obj_x,
  output logic [6:0] obj_y,
  output logic [1:0] state_dbg
);

  localparam int CXW = $clog2(SPRITE_W);
  localparam int CYW = $clog2(SPRITE_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    lfsr;
  logic           lfsr_fb;
  logic           ph;
  logic           kind_gold;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           any_req;
  logic           start;
  logic           last_px;
  logic           clr_n;

  assign clr_n     = resetn_gold_stone;
  assign any_req   = enable_draw_gold | enable_draw_stone;
  assign start     = (state == S_IDLE) && any_req;
  assign last_px   = (cx == CXW'(SPRITE_W - 1)) && (cy == CYW'(SPRITE_H - 1));
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign state_dbg = state;

  // Free-running Fibonacci LFSR (taps 16,14,13,11); only the async reset reseeds it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; the synchronous clear aborts any sprite back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_DRAW;
      S_DRAW: if (last_px) state_nxt = S_DONE;
      S_DONE: state_nxt = S_WAIT;
      S_WAIT: if (!any_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (!clr_n) state_nxt = S_IDLE;
  end

  // Position generation: x on the first enable_random cycle, y on the second.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph    <= 1'b0;
      obj_x <= '0;
      obj_y <= '0;
    end else if (!clr_n) begin
      ph <= 1'b0;
    end else if (enable_random && (state == S_IDLE)) begin
      if (!ph) obj_x <= 8'(X_MIN) + {1'b0, lfsr[6:0]};
      else     obj_y <= 7'(Y_MIN) + {1'b0, lfsr[5:0]};
      ph <= ~ph;
    end
  end

  // Sprite kind and raster counters; gold wins when both requests are high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kind_gold <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else if (start) begin
      kind_gold <= enable_draw_gold;
      cx        <= '0;
      cy        <= '0;
    end else if (state == S_DRAW) begin
      cx <= cx + CXW'(1);
      if (cx == CXW'(SPRITE_W - 1)) cy <= cy + CYW'(1);
    end
  end

  // Registered VGA pixel outputs and done pulses; clear suppresses both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_out           <= '0;
      y_out           <= '0;
      colour          <= '0;
      plot            <= 1'b0;
      draw_gold_done  <= 1'b0;
      draw_stone_done <= 1'b0;
    end else begin
      x_out           <= obj_x + 8'(cx);
      y_out           <= obj_y + 7'(cy);
      plot            <= clr_n && (state == S_DRAW);
      colour          <= (clr_n && (state == S_DRAW)) ?
                         (kind_gold ? GOLD_COLOUR : STONE_COLOUR) : 3'b000;
      draw_gold_done  <= clr_n && (state == S_DONE) && kind_gold;
      draw_stone_done <= clr_n && (state == S_DONE) && !kind_gold;
    end
  end

  // Sprite counters, saturating at 7; clear beats increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gold_count  <= '0;
      stone_count <= '0;
    end else if (!clr_n) begin
      gold_count  <= '0;
      stone_count <= '0;
    end else if (state == S_DONE) begin
      if (kind_gold && (gold_count != 3'd7))   gold_count  <= gold_count + 3'd1;
      if (!kind_gold && (stone_count != 3'd7)) stone_count <= stone_count + 3'd1;
    end
  end

endmodule

// File: tb/tb_object_sprite_drawer.sv
// Directed testbench for object_sprite_drawer: position generation, gold and
// stone sprite rasterisation, count saturation, clear abort and async reset.
module tb_object_sprite_drawer;

  localparam logic [2:0] GOLD_C  = 3'b110;
  localparam logic [2:0] STONE_C = 3'b111;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       resetn_gold_stone = 1'b1;
  logic       enable_random = 1'b0;
  logic       enable_draw_gold = 1'b0;
  logic       enable_draw_stone = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       draw_gold_done;
  logic       draw_stone_done;
  logic [2:0] gold_count;
  logic [2:0] stone_count;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic [1:0] state_dbg;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  int          plot_cycles = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_x;
  logic [6:0]  exp_y;
  int          exp_gold = 0;
  int          exp_stone = 0;
  logic [7:0]  pu_x;
  logic [6:0]  pu_y;

  // ---------------- clock / reference LFSR ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  object_sprite_drawer dut (
    .clk               (clk),
    .resetn            (resetn),
    .resetn_gold_stone (resetn_gold_stone),
    .enable_random     (enable_random),
    .enable_draw_gold  (enable_draw_gold),
    .enable_draw_stone (enable_draw_stone),
    .x_out             (x_out),
    .y_out             (y_out),
    .colour            (colour),
    .plot              (plot),
    .draw_gold_done    (draw_gold_done),
    .draw_stone_done   (draw_stone_done),
    .gold_count        (gold_count),
    .stone_count       (stone_count),
    .obj_x             (obj_x),
    .obj_y             (obj_y),
    .state_dbg         (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every plotted pixel must match the next expected {x,y,colour}.
  always @(negedge clk) begin
    if (plot) begin
      plot_cycles++;
      check("plot_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pixel", {14'd0, x_out, y_out, colour}, {14'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_sprite(input logic gold);
    for (int cy = 0; cy < 8; cy++)
      for (int cx = 0; cx < 8; cx++)
        exp_q.push_back({exp_x + 8'(cx), exp_y + 7'(cy), gold ? GOLD_C : STONE_C});
  endtask

  task automatic gen_pos();
    enable_random = 1'b1;
    exp_x = 8'd16 + {1'b0, m_lfsr[6:0]};
    step();
    exp_y = 7'd40 + {1'b0, m_lfsr[5:0]};
    step();
    enable_random = 1'b0;
    check("obj_x", obj_x, exp_x);
    check("obj_y", obj_y, exp_y);
  endtask

  task automatic draw(input logic gold, input int hold_extra);
    int  k;
    int  base;
    bit  seen;
    push_sprite(gold);
    base = plot_cycles;
    if (gold) enable_draw_gold = 1'b1;
    else      enable_draw_stone = 1'b1;
    k = -1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      step();
      k++;
      if (k == 0) check("plot_before_first", plot, 0);
      if (k == 1) check("plot_first", plot, 1);
      if (gold ? draw_gold_done : draw_stone_done) seen = 1'b1;
      check("other_done_low", gold ? draw_stone_done : draw_gold_done, 0);
    end
    check(gold ? "gold_done_cycle" : "stone_done_cycle", k, 65);
    if (gold) exp_gold  = (exp_gold  < 7) ? exp_gold + 1  : 7;
    else      exp_stone = (exp_stone < 7) ? exp_stone + 1 : 7;
    check("gold_count_at_done", gold_count, exp_gold);
    check("stone_count_at_done", stone_count, exp_stone);
    check("plot_cycles", plot_cycles - base, 64);
    for (int i = 0; i < hold_extra; i++) begin
      step();
      check("done_single_hold", gold ? draw_gold_done : draw_stone_done, 0);
      check("plot_idle_hold", plot, 0);
    end
    enable_draw_gold = 1'b0;
    enable_draw_stone = 1'b0;
    step();
    check("done_single", gold ? draw_gold_done : draw_stone_done, 0);
    step();
    step();
    check("state_idle_after", state_dbg, 0);
    check("plot_cycles_after", plot_cycles - base, 64);
    check("gold_count_after", gold_count, exp_gold);
    check("stone_count_after", stone_count, exp_stone);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x_out"}, x_out, 0);
    check({tag, "_y_out"}, y_out, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_gold_done"}, draw_gold_done, 0);
    check({tag, "_stone_done"}, draw_stone_done, 0);
    check({tag, "_gold_count"}, gold_count, 0);
    check({tag, "_stone_count"}, stone_count, 0);
    check({tag, "_obj_x"}, obj_x, 0);
    check({tag, "_obj_y"}, obj_y, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    int         k;

    // Power-up reset
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    step();
    step();
    gen_pos();
    pu_x = exp_x;
    pu_y = exp_y;

    // First gold sprite
    check("gold_count_before", gold_count, 0);
    draw(1'b1, 0);

    // Clear, then six gold and two stone sprites
    resetn_gold_stone = 1'b0;
    step();
    resetn_gold_stone = 1'b1;
    exp_gold = 0;
    exp_stone = 0;
    check("clear_gold", gold_count, 0);
    for (int i = 0; i < 6; i++) begin
      gen_pos();
      draw(1'b1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      gen_pos();
      draw(1'b0, 0);
    end
    check("gold_six", gold_count, 6);
    check("stone_two", stone_count, 2);

    // Request held three cycles after done, then saturation at 7
    gen_pos();
    draw(1'b1, 3);
    check("gold_seven", gold_count, 7);
    gen_pos();
    draw(1'b1, 0);
    check("gold_saturate", gold_count, 7);

    // 200 random position pairs
    prev_x = obj_x;
    prev_y = obj_y;
    for (int i = 0; i < 200; i++) begin
      gen_pos();
      check("x_in_range", 32'((obj_x >= 8'd16) && (obj_x <= 8'd143)), 1);
      check("y_in_range", 32'((obj_y >= 7'd40) && (obj_y <= 7'd103)), 1);
      check("pair_changes", 32'({prev_x, prev_y} != {obj_x, obj_y}), 1);
      prev_x = obj_x;
      prev_y = obj_y;
    end

    // Clear at pixel 20 of a stone sprite
    gen_pos();
    push_sprite(1'b0);
    enable_draw_stone = 1'b1;
    k = -1;
    while (k < 21) begin
      step();
      k++;
      check("abort_no_done_early", draw_stone_done, 0);
    end
    check("abort_plot_px20", plot, 1);
    resetn_gold_stone = 1'b0;
    enable_draw_stone = 1'b0;
    step();
    check("abort_plot", plot, 0);
    check("abort_stone_done", draw_stone_done, 0);
    check("abort_gold_count", gold_count, 0);
    check("abort_stone_count", stone_count, 0);
    check("abort_state", state_dbg, 0);
    resetn_gold_stone = 1'b1;
    exp_q.delete();
    exp_gold = 0;
    exp_stone = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done_late", draw_stone_done, 0);
      check("abort_plot_late", plot, 0);
    end

    // A stone sprite after the clear, then async reset mid-draw
    gen_pos();
    draw(1'b0, 0);
    gen_pos();
    push_sprite(1'b1);
    enable_draw_gold = 1'b1;
    repeat (10) step();
    check("mid_draw_plot", plot, 1);
    #2;
    resetn = 1'b0;
    enable_draw_gold = 1'b0;
    #1;
    check_all_zero("async");
    exp_q.delete();
    exp_gold = 0;
    exp_stone = 0;
    step();
    step();
    resetn = 1'b1;
    step();
    step();
    gen_pos();
    check("replay_x", obj_x, pu_x);
    check("replay_y", obj_y, pu_y);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
